// File: rtl/hazard_track_unit.sv
// Pipeline hazard tracker: follows destination/write-enable of the EXE, MEM and WB
// stages and raises a same-cycle stall request for RAW dependencies of the ID instruction.
module hazard_track_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_forwarding,
    input  logic       freeze,
    input  logic       flush,
    input  logic [3:0] ID_dst,
    input  logic       ID_wb_en,
    input  logic       ID_mem_read,
    input  logic [3:0] ID_src1,
    input  logic [3:0] ID_src2,
    input  logic       ID_two_src,
    output logic [3:0] EXE_dst,
    output logic [3:0] MEM_dst,
    output logic [3:0] WB_dst,
    output logic       EXE_wb_en,
    output logic       MEM_wb_en,
    output logic       WB_wb_en,
    output logic       EXE_mem_read,
    output logic       hazard,
    output logic [7:0] stall_count
);

    logic exe_match;
    logic mem_match;
    logic insert_bubble;

    function automatic logic slot_match(
        input logic [3:0] dst,
        input logic       wb_en,
        input logic [3:0] src1,
        input logic [3:0] src2,
        input logic       two_src
    );
        return wb_en && ((dst == src1) || (two_src && (dst == src2)));
    endfunction

    // WB is never consulted: the register file writes in the first half-cycle.
    always_comb begin
        exe_match = slot_match(EXE_dst, EXE_wb_en, ID_src1, ID_src2, ID_two_src);
        mem_match = slot_match(MEM_dst, MEM_wb_en, ID_src1, ID_src2, ID_two_src);
        if (flush) begin
            hazard = 1'b0;
        end else if (en_forwarding) begin
            hazard = exe_match && EXE_mem_read;
        end else begin
            hazard = exe_match || mem_match;
        end
        insert_bubble = flush || hazard;
    end

    // The load flag only matters while the instruction sits in EXE, so later slots drop it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            EXE_dst      <= '0;
            EXE_wb_en    <= 1'b0;
            EXE_mem_read <= 1'b0;
            MEM_dst      <= '0;
            MEM_wb_en    <= 1'b0;
            WB_dst       <= '0;
            WB_wb_en     <= 1'b0;
            stall_count  <= '0;
        end else if (!freeze) begin
            WB_dst    <= MEM_dst;
            WB_wb_en  <= MEM_wb_en;
            MEM_dst   <= EXE_dst;
            MEM_wb_en <= EXE_wb_en;
            if (insert_bubble) begin
                EXE_dst      <= '0;
                EXE_wb_en    <= 1'b0;
                EXE_mem_read <= 1'b0;
            end else begin
                EXE_dst      <= ID_dst;
                EXE_wb_en    <= ID_wb_en;
                EXE_mem_read <= ID_mem_read;
            end
            if (hazard && (stall_count != '1)) begin
                stall_count <= stall_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/hazard_track_unit.md
HAZARD_TRACK_UNIT -- requirements
Module: hazard_track_unit

Interface
REQ-001 SHALL provide ports, clock and reset first, one per line:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- en_forwarding  input  1  forwarding enabled in datapath
- freeze  input  1  memory stall; hold all stage state
- flush  input  1  taken branch; squash instruction entering EXE
- ID_dst  input  4  decoded destination register
- ID_wb_en  input  1  ID instruction writes register file
- ID_mem_read  input  1  ID instruction is a load
- ID_src1  input  4  first source register
- ID_src2  input  4  second source register
- ID_two_src  input  1  ID_src2 is a real operand
- EXE_dst, MEM_dst, WB_dst  output  4 each  destination tracked per stage
- EXE_wb_en, MEM_wb_en, WB_wb_en  output  1 each  write-enable tracked per stage
- EXE_mem_read  output  1  EXE slot holds a load
- hazard  output  1  stall request to IF/ID (hold PC and IF/ID register)
- stall_count  output  8  saturating count of hazard stall cycles

Function
REQ-002 SHALL hold three stage slots (EXE, MEM, WB), each {dst[3:0], wb_en, mem_read}; slot contents drive the same-named outputs directly from registers.
REQ-003 SHALL, on each rising edge with freeze=0: WB <= MEM, MEM <= EXE, EXE <= ID inputs or bubble per REQ-006.
REQ-004 SHALL, with freeze=1, hold all slots and stall_count unchanged; freeze overrides flush and hazard.
REQ-005 SHALL define match(x) = x_wb_en AND ((x_dst==ID_src1) OR (ID_two_src AND x_dst==ID_src2)) for slot x.
REQ-006 SHALL load a bubble (dst=0, wb_en=0, mem_read=0) into EXE when flush=1 or hazard=1; otherwise load {ID_dst, ID_wb_en, ID_mem_read}.
REQ-007 SHALL compute hazard combinationally: en_forwarding=0 -> match(EXE) OR match(MEM); en_forwarding=1 -> match(EXE) AND EXE_mem_read.
REQ-008 SHALL never assert hazard from a WB-slot match (register file writes in first half-cycle).
REQ-009 SHALL force hazard=0 when flush=1 (squashed instruction needs no stall).
REQ-010 SHALL treat ID_src2 as don't-care when ID_two_src=0, including when equal to a pending dst.
REQ-011 SHALL increment stall_count by 1 on each edge with hazard=1 and freeze=0; saturate at 8'hFF (no wrap).
REQ-012 SHALL give hazard zero-cycle latency from ID inputs; stage outputs update one cycle after capture.
REQ-013 SHALL make a load-use stall last exactly 1 cycle with forwarding enabled, and a dependent stall last at most 2 cycles with forwarding disabled, absent freeze.
REQ-014 SHALL with simultaneous flush and hazard load a single bubble and not increment stall_count.

Reset
REQ-015 SHALL, on rst=0, asynchronously clear all slots (dst=0, wb_en=0, mem_read=0) and stall_count=0, independent of clk.
REQ-016 SHALL output hazard=0 during reset regardless of ID inputs (all wb_en clear).
REQ-017 SHALL resume normal capture on the first rising edge after rst returns to 1; reset mid-stall discards pending slots.

Verification
REQ-018 SHALL cover: en_forwarding=1, load writes R3 in EXE, ID_src1=3 -> hazard=1 one cycle, EXE bubble, next cycle hazard=0, stall_count=1.
REQ-019 SHALL cover: en_forwarding=0, ALU write R5 captured, next ID_src2=5 with two_src=1 -> hazard=1 two cycles (EXE then MEM), then 0, stall_count=2.
REQ-020 SHALL cover: same as REQ-019 but ID_two_src=0 -> hazard=0, no bubble, stall_count=0.
REQ-021 SHALL cover: hazard=1 with freeze=1 held 3 cycles -> slots and stall_count unchanged; release freeze -> bubble inserted, count+1.
REQ-022 SHALL cover: flush=1 with matching load in EXE -> hazard=0, EXE becomes bubble, stall_count unchanged.
REQ-023 SHALL cover: stall_count preloaded to 255 by repeated stalls, one more stall -> stays 255; rst=0 mid-cycle -> all outputs 0 immediately.
